// File: rtl/relais_pkg.sv
// rtl/relais_pkg.sv - shared types, defaults and width helper for the relay bank
package relais_pkg;

    localparam int N_CH_DEF = 4;
    localparam int W_DEF    = 12;
    localparam int T_W_DEF  = 8;
    localparam int C_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_OPEN   = 2'd0,
        ST_PULL   = 2'd1,
        ST_CLOSED = 2'd2,
        ST_DROP   = 2'd3
    } relais_state_t;

    // hi/lo thresholds need one extra bit so vt +/- vh never wraps
    function automatic int hl_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/relais_bank_if.sv
// rtl/relais_bank_if.sv - signal bundle for driving and observing a relay bank
interface relais_bank_if #(
    parameter int N_CH = 4,
    parameter int W    = 12,
    parameter int T_W  = 8,
    parameter int C_W  = 16
);
    logic [N_CH*W-1:0]   coil;
    logic [N_CH-1:0]     coil_vld;
    logic [W-1:0]        vt;
    logic [W-2:0]        vh;
    logic [T_W-1:0]      t_on;
    logic [T_W-1:0]      t_off;
    logic                cnt_clr;
    logic [N_CH-1:0]     closed;
    logic [N_CH-1:0]     busy;
    logic [N_CH-1:0]     chg;
    logic [N_CH*C_W-1:0] ncl;

    modport master (
        output coil, coil_vld, vt, vh, t_on, t_off, cnt_clr,
        input  closed, busy, chg, ncl
    );

    modport slave (
        input  coil, coil_vld, vt, vh, t_on, t_off, cnt_clr,
        output closed, busy, chg, ncl
    );
endinterface

// File: rtl/relais_ch.sv
// rtl/relais_ch.sv - one relay channel: hysteresis FSM, pull-in/drop-out timer, closure counter
module relais_ch
    import relais_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int T_W = T_W_DEF,
    parameter int C_W = C_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [W-1:0]  coil,
    input  logic                 coil_vld,
    input  logic signed [W:0]    hi,
    input  logic signed [W:0]    lo,
    input  logic [T_W-1:0]       t_on,
    input  logic [T_W-1:0]       t_off,
    input  logic                 cnt_clr,
    output logic                 closed,
    output logic                 busy,
    output logic                 chg,
    output logic [C_W-1:0]       ncl
);

    localparam logic [C_W-1:0] NCL_MAX = {C_W{1'b1}};

    relais_state_t        state;
    logic [T_W-1:0]       timer;
    logic signed [W:0]    coil_x;
    logic                 above_hi;
    logic                 below_lo;
    logic                 expire;
    logic                 close_evt;

    assign coil_x = {coil[W-1], coil};

    // Threshold decisions and the OPEN->closed event that feeds the counter
    always_comb begin
        above_hi  = coil_vld && (coil_x > hi);
        below_lo  = coil_vld && (coil_x < lo);
        expire    = (timer <= T_W'(1));
        close_evt = 1'b0;
        case (state)
            ST_OPEN: close_evt = above_hi && (t_on == '0);
            ST_PULL: close_evt = !(coil_vld && !above_hi) && expire;
            default: close_evt = 1'b0;
        endcase
    end

    // Channel FSM with registered contact, busy, change pulse and closure count
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_OPEN;
            timer  <= '0;
            closed <= 1'b0;
            busy   <= 1'b0;
            chg    <= 1'b0;
            ncl    <= '0;
        end else begin
            chg <= 1'b0;

            if (cnt_clr) begin
                ncl <= '0;
            end else if (close_evt && (ncl != NCL_MAX)) begin
                ncl <= ncl + C_W'(1);
            end

            case (state)
                ST_OPEN: begin
                    if (above_hi) begin
                        if (t_on == '0) begin
                            state  <= ST_CLOSED;
                            closed <= 1'b1;
                            chg    <= 1'b1;
                        end else begin
                            state <= ST_PULL;
                            timer <= t_on;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_PULL: begin
                    if (coil_vld && !above_hi) begin
                        // abort: contact never moved, so no change pulse
                        state <= ST_OPEN;
                        timer <= '0;
                        busy  <= 1'b0;
                    end else if (expire) begin
                        state  <= ST_CLOSED;
                        timer  <= '0;
                        busy   <= 1'b0;
                        closed <= 1'b1;
                        chg    <= 1'b1;
                    end else begin
                        timer <= timer - T_W'(1);
                    end
                end
                ST_CLOSED: begin
                    if (below_lo) begin
                        if (t_off == '0) begin
                            state  <= ST_OPEN;
                            closed <= 1'b0;
                            chg    <= 1'b1;
                        end else begin
                            state <= ST_DROP;
                            timer <= t_off;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (coil_vld && !below_lo) begin
                        state <= ST_CLOSED;
                        timer <= '0;
                        busy  <= 1'b0;
                    end else if (expire) begin
                        state  <= ST_OPEN;
                        timer  <= '0;
                        busy   <= 1'b0;
                        closed <= 1'b0;
                        chg    <= 1'b1;
                    end else begin
                        timer <= timer - T_W'(1);
                    end
                end
                default: begin
                    state <= ST_OPEN;
                    timer <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/relais_bank.sv
// rtl/relais_bank.sv - bank of independent hysteretic relay channels with shared thresholds
module relais_bank
    import relais_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int W    = W_DEF,
    parameter int T_W  = T_W_DEF,
    parameter int C_W  = C_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH*W-1:0]   coil,
    input  logic [N_CH-1:0]     coil_vld,
    input  logic [W-1:0]        vt,
    input  logic [W-2:0]        vh,
    input  logic [T_W-1:0]      t_on,
    input  logic [T_W-1:0]      t_off,
    input  logic                cnt_clr,
    output logic [N_CH-1:0]     closed,
    output logic [N_CH-1:0]     busy,
    output logic [N_CH-1:0]     chg,
    output logic [N_CH*C_W-1:0] ncl
);

    localparam int HW = hl_width(W);

    logic signed [HW-1:0] hi;
    logic signed [HW-1:0] lo;

    // Shared thresholds computed once; sign-extended vt, zero-extended vh
    always_comb begin
        hi = $signed({vt[W-1], vt}) + $signed({2'b00, vh});
        lo = $signed({vt[W-1], vt}) - $signed({2'b00, vh});
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        relais_ch #(
            .W   (W),
            .T_W (T_W),
            .C_W (C_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .coil     ($signed(coil[i*W +: W])),
            .coil_vld (coil_vld[i]),
            .hi       (hi),
            .lo       (lo),
            .t_on     (t_on),
            .t_off    (t_off),
            .cnt_clr  (cnt_clr),
            .closed   (closed[i]),
            .busy     (busy[i]),
            .chg      (chg[i]),
            .ncl      (ncl[i*C_W +: C_W])
        );
    end

endmodule

// File: doc/relais_bank.md
RELAIS_BANK -- requirements
Module: relais_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent relay channels (1..32).
REQ-002 SHALL have parameter W, default 12: coil sample width, signed two's complement.
REQ-003 SHALL have parameter T_W, default 8: pull-in/drop-out timer width, unsigned.
REQ-004 SHALL have parameter C_W, default 16: per-channel closure counter width.
REQ-005 SHALL have these ports: clk input 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have these ports: rst input 1, synchronous active-high reset.
REQ-007 SHALL have these ports: coil input N_CH*W, per-channel coil samples; channel i at bits [i*W +: W].
REQ-008 SHALL have these ports: coil_vld input N_CH, per-channel sample-valid qualifier.
REQ-009 SHALL have these ports: vt input W, signed threshold; shared by all channels.
REQ-010 SHALL have these ports: vh input W-1, unsigned hysteresis; shared.
REQ-011 SHALL have these ports: t_on input T_W, pull-in delay in clk cycles.
REQ-012 SHALL have these ports: t_off input T_W, drop-out delay in clk cycles.
REQ-013 SHALL have these ports: cnt_clr input 1, synchronous clear of all closure counters.
REQ-014 SHALL have these ports: closed output N_CH, registered contact state, 1 = closed.
REQ-015 SHALL have these ports: busy output N_CH, 1 while the channel is in PULL or DROP.
REQ-016 SHALL have these ports: chg output N_CH, one-cycle pulse when closed toggles.
REQ-017 SHALL have these ports: ncl output N_CH*C_W, per-channel saturating closure count.

Function
REQ-018 SHALL compute hi = vt+vh and lo = vt-vh at width W+1 signed, with no overflow or saturation.
REQ-019 SHALL per channel run a 4-state FSM: OPEN, PULL, CLOSED, DROP; closed=1 only in CLOSED and DROP.
REQ-020 SHALL, in OPEN with coil_vld=1 and coil>hi, move to PULL and load timer=t_on; if t_on=0, move straight to CLOSED.
REQ-021 SHALL, in PULL, decrement the timer each clk, then move to CLOSED on the cycle the timer reaches 0.
REQ-022 SHALL, in PULL, abort to OPEN on any valid sample with coil<=hi, with no chg pulse.
REQ-023 SHALL apply the mirror image in CLOSED/DROP: enter on a valid coil<lo and load t_off; t_off=0 goes directly to OPEN; a valid coil>=lo in DROP aborts to CLOSED.
REQ-024 SHALL hold the state when coil_vld=0; timers keep counting.
REQ-025 SHALL treat samples with lo<=coil<=hi as no change in OPEN and CLOSED.
REQ-026 SHALL update closed one cycle after the deciding sample or timer expiry; chg SHALL be asserted in that same cycle.
REQ-027 SHALL increment ncl on each OPEN->closed transition and saturate at 2^C_W-1.
REQ-028 SHALL let cnt_clr win over a simultaneous increment; the count SHALL be 0 next cycle.
REQ-029 SHALL sample t_on/t_off only at timer load; changes during PULL/DROP SHALL not affect the running count.
REQ-030 SHALL keep channels fully independent; no cross-channel ordering or arbitration.

Reset
REQ-031 SHALL, on rst=1 at a clk edge, put all FSMs in OPEN, zero all timers, drive closed=0, busy=0, chg=0 and ncl=0.
REQ-032 SHALL let rst override every other input, including mid-PULL/DROP; no chg pulse SHALL result from reset.

Structure
REQ-033 SHALL place the state enum, the hi/lo width helper and default parameter constants in package relais_pkg.
REQ-034 SHALL implement one channel as sub-module relais_ch (FSM, timer, counter), generated N_CH times; relais_bank computes hi/lo once.

Verification
REQ-035 SHALL cover pull-in: W=12, vt=500, vh=100, t_on=3, ch0 coil=601 valid -> closed[0]=1 and chg[0] pulse 4 cycles later; ncl0=1.
REQ-036 SHALL cover hysteresis: from CLOSED, coil=450 -> no change; coil=399 with t_off=0 -> closed=0 next cycle.
REQ-037 SHALL cover abort: t_on=5, coil=700 then coil=550 two cycles later -> back to OPEN, closed stays 0, no chg.
REQ-038 SHALL cover saturation/clear: C_W=2, 4 closures -> ncl=3; cnt_clr coincident with a 5th closure -> ncl=0.
REQ-039 SHALL cover reset mid-DROP: rst asserted -> all outputs 0 next cycle, no chg pulse.
REQ-040 SHALL cover independence: N_CH=4, distinct stimuli per channel -> each channel matches a single-channel reference model.
